// File: rtl/mips_r2000_core_if.sv
// Data-memory bus between the core datapath and its data memory.
// Word-addressed: addr is already the word index, byte offset dropped.
interface mips_r2000_core_if #(
  parameter int AW = 10
) ();
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mips_r2000_core.sv
// Single-cycle MIPS R2000 subset core with built-in instruction and data
// memories. Every instruction fetches, executes and commits on one CLK edge.
// Optional feature: define MIPS_R2000_SHIFTV_EN to add sllv/srlv/srav;
// without it those encodings behave as NOPs like any other unsupported op.
module mips_r2000_core #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic CLK,
  input logic RST
);
  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;
`ifdef MIPS_R2000_SHIFTV_EN
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
`endif

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] daddr;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_we;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic        unused_daddr_bits;

  mips_r2000_core_if #(.AW(DAW)) dbus ();

  mips_r2000_pcu #(.RESET_PC(RESET_PC)) U_PCU (
    .CLK          (CLK),
    .RST          (RST),
    .next_pc      (next_pc),
    .PCRegDataOut (pc)
  );

  mips_r2000_imem #(.IMEM_WORDS(IMEM_WORDS), .AW(IAW)) U_InstructionMemory (
    .addr  (pc[2 +: IAW]),
    .rdata (instr)
  );

  mips_r2000_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_data_memory (
    .CLK (CLK),
    .bus (dbus)
  );

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign pc_plus4 = pc + 32'd4;

  assign rs_val = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : regs_q[rt];
  assign daddr  = rs_val + imm_sext;

  // Byte offset and bits above the memory depth are ignored, so the address wraps.
  assign unused_daddr_bits = ^{daddr[31:2+DAW], daddr[1:0]};

  // Stores are suppressed while reset is held so an aborted instruction never commits.
  assign dbus.addr  = daddr[2 +: DAW];
  assign dbus.wdata = rt_val;
  assign dbus.we    = mem_we & RST;

  // Decode and execute: pick the register/memory write and the next PC for this instruction.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    mem_we   = 1'b0;
    next_pc  = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        rf_waddr = rd;
        rf_we    = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: rf_wdata = rs_val + rt_val;
          FN_SUB, FN_SUBU: rf_wdata = rs_val - rt_val;
          FN_AND:          rf_wdata = rs_val & rt_val;
          FN_OR:           rf_wdata = rs_val | rt_val;
          FN_XOR:          rf_wdata = rs_val ^ rt_val;
          FN_NOR:          rf_wdata = ~(rs_val | rt_val);
          FN_SLT:          rf_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU:         rf_wdata = {31'h0, rs_val < rt_val};
          FN_SLL:          rf_wdata = rt_val << shamt;
          FN_SRL:          rf_wdata = rt_val >> shamt;
          FN_SRA:          rf_wdata = $signed(rt_val) >>> shamt;
`ifdef MIPS_R2000_SHIFTV_EN
          FN_SLLV:         rf_wdata = rt_val << rs_val[4:0];
          FN_SRLV:         rf_wdata = rt_val >> rs_val[4:0];
          FN_SRAV:         rf_wdata = $signed(rt_val) >>> rs_val[4:0];
`endif
          FN_JR: begin
            rf_we   = 1'b0;
            next_pc = rs_val;
          end
          default:         rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val + imm_sext;
      end
      OP_SLTI: begin
        rf_we = 1'b1; rf_waddr = rt;
        rf_wdata = {31'h0, $signed(rs_val) < $signed(imm_sext)};
      end
      OP_SLTIU: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = {31'h0, rs_val < imm_sext};
      end
      OP_ANDI: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val & imm_zext;
      end
      OP_ORI: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val | imm_zext;
      end
      OP_XORI: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = rs_val ^ imm_zext;
      end
      OP_LUI: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = {imm, 16'h0000};
      end
      OP_LW: begin
        rf_we = 1'b1; rf_waddr = rt; rf_wdata = dbus.rdata;
      end
      OP_SW: mem_we = 1'b1;
      OP_BEQ: if (rs_val == rt_val) next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
      OP_BNE: if (rs_val != rt_val) next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
      OP_J:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      OP_JAL: begin
        next_pc  = {pc_plus4[31:28], instr[25:0], 2'b00};
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_plus4;
      end
      default: ;
    endcase
  end

  // Register file next state: apply the single write port; $0 is hard-wired to zero.
  always_comb begin
    regs_d = regs_q;
    if (rf_we) regs_d[rf_waddr] = rf_wdata;
    regs_d[0] = 32'h0;
  end

  // Register file state, cleared asynchronously while reset is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// Program counter register; PCRegDataOut is monitored hierarchically.
module mips_r2000_pcu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] next_pc,
  output logic [31:0] PCRegDataOut
);
  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next PC is chosen by the datapath; this block only registers it.
  always_comb pc_d = next_pc;

  // PC state, forced to the reset vector while reset is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign PCRegDataOut = pc_q;
endmodule

// Instruction memory: combinational read, contents loaded externally by path.
module mips_r2000_imem #(
  parameter int IMEM_WORDS = 1024,
  parameter int AW         = 10
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] IMem [IMEM_WORDS];

  assign rdata = IMem[addr];
endmodule

// Data memory: combinational read, synchronous write, not touched by reset.
module mips_r2000_dmem #(
  parameter int DMEM_WORDS = 1024
) (
  input logic              CLK,
  mips_r2000_core_if.slave bus
);
  logic [31:0] dmem [DMEM_WORDS];

  assign bus.rdata = dmem[bus.addr];

  // Commit a store on the rising edge.
  always_ff @(posedge CLK) begin
    if (bus.we) dmem[bus.addr] <= bus.wdata;
  end
endmodule

// File: tb/tb_mips_r2000_core.sv
// Self-checking bench for mips_r2000_core: directed programs plus random
// programs compared cycle by cycle against an instruction-level model.
module tb_mips_r2000_core;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  mips_r2000_core #(
    .IMEM_WORDS (1024),
    .DMEM_WORDS (1024),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .RST (RST)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] encR(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] encI(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] encJ(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic clearProgram();
    for (int i = 0; i < 1024; i++) begin
      m_imem[i] = 32'h0;
      dut.U_InstructionMemory.IMem[i] = 32'h0;
    end
  endtask

  task automatic putInstr(input int byte_addr, input logic [31:0] word);
    m_imem[byte_addr / 4] = word;
    dut.U_InstructionMemory.IMem[byte_addr / 4] = word;
  endtask

  task automatic modelReset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Instruction-set level model: one call retires one instruction.
  task automatic modelStep();
    logic [31:0] ins, a, b, se, ze, ea, seq_pc, npc, res;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    int          dst;
    ins = m_imem[m_pc[11:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    a  = m_regs[rs];
    b  = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    ea = a + se;
    seq_pc = m_pc + 32'd4;
    npc = seq_pc;
    dst = -1;
    res = 32'h0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: begin dst = rd; res = a + b; end
          6'h22, 6'h23: begin dst = rd; res = a - b; end
          6'h24: begin dst = rd; res = a & b; end
          6'h25: begin dst = rd; res = a | b; end
          6'h26: begin dst = rd; res = a ^ b; end
          6'h27: begin dst = rd; res = ~(a | b); end
          6'h2a: begin dst = rd; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
          6'h2b: begin dst = rd; res = (a < b) ? 32'd1 : 32'd0; end
          6'h00: begin dst = rd; res = b << sh; end
          6'h02: begin dst = rd; res = b >> sh; end
          6'h03: begin dst = rd; res = 32'(int'(b) >>> sh); end
          6'h08: npc = a;
`ifdef MIPS_R2000_SHIFTV_EN
          6'h04: begin dst = rd; res = b << a[4:0]; end
          6'h06: begin dst = rd; res = b >> a[4:0]; end
          6'h07: begin dst = rd; res = 32'(int'(b) >>> a[4:0]); end
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09: begin dst = rt; res = a + se; end
      6'h0a: begin dst = rt; res = (int'(a) < int'(se)) ? 32'd1 : 32'd0; end
      6'h0b: begin dst = rt; res = (a < se) ? 32'd1 : 32'd0; end
      6'h0c: begin dst = rt; res = a & ze; end
      6'h0d: begin dst = rt; res = a | ze; end
      6'h0e: begin dst = rt; res = a ^ ze; end
      6'h0f: begin dst = rt; res = ze << 16; end
      6'h23: begin dst = rt; res = m_dmem[ea[11:2]]; end
      6'h2b: m_dmem[ea[11:2]] = b;
      6'h04: if (a == b) npc = seq_pc + (se << 2);
      6'h05: if (a != b) npc = seq_pc + (se << 2);
      6'h02: npc = {seq_pc[31:28], ins[25:0], 2'b00};
      6'h03: begin dst = 31; res = seq_pc; npc = {seq_pc[31:28], ins[25:0], 2'b00}; end
      default: ;
    endcase
    if (dst > 0) m_regs[dst] = res;
    m_pc = npc;
  endtask

  // One instruction: DUT commits on the rising edge, model retires alongside,
  // outputs are then sampled on the falling edge.
  task automatic applyStimulus();
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
  endtask

  task automatic checkAll();
    checkOutput("pc", dut.U_PCU.PCRegDataOut, m_pc);
    checkOutput("instr", dut.instr, m_imem[m_pc[11:2]]);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("r%0d", i), dut.regs_q[i], m_regs[i]);
  endtask

  task automatic assertReset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("rst_pc", dut.U_PCU.PCRegDataOut, 32'h0000_0000);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("rst_r%0d", i), dut.regs_q[i], 32'h0);
    modelReset();
  endtask

  task automatic releaseReset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  function automatic logic [5:0] pickFunct(int k);
    case (k)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2a;  9: return 6'h2b; 10: return 6'h00; 11: return 6'h02;
      12: return 6'h03; 13: return 6'h04; 14: return 6'h06; 15: return 6'h07;
      16: return 6'h05;
      default: return 6'h3f;
    endcase
  endfunction

  function automatic logic [31:0] randInstr();
    int kind, rs, rt, rd, imm;
    kind = int'($urandom_range(0, 9));
    rs   = int'($urandom_range(0, 9));
    rt   = int'($urandom_range(0, 9));
    rd   = int'($urandom_range(0, 9));
    imm  = int'($urandom_range(0, 65535));
    case (kind)
      0, 1, 2: return encR(rs, rt, rd, int'($urandom_range(0, 31)),
                           int'(pickFunct(int'($urandom_range(0, 17)))));
      3, 4, 5: return encI(8 + int'($urandom_range(0, 7)), rs, rt, imm);
      6: return encI(6'h23, 0, rt, 32'h40 + 4 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 3)));
      7: return encI(6'h2b, 0, rt, 32'h40 + 4 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 3)));
      8: return encI(4 + int'($urandom_range(0, 1)), rs, rt, int'($urandom_range(1, 4)));
      default: return {6'h3f - 6'($urandom_range(0, 1)), 26'($urandom)};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) m_dmem[i] = 32'h0;
    modelReset();
    #1 RST = 1'b0;

    // Program A: ALU, memory, $0, overflow, undefined opcode, not-taken bne.
    clearProgram();
    putInstr(32'h00, encI(6'h0d, 0, 1, 32'h1234));
    putInstr(32'h04, encI(6'h0f, 0, 2, 32'h8000));
    putInstr(32'h08, encR(1, 2, 3, 0, 6'h21));
    putInstr(32'h0C, encR(2, 1, 4, 0, 6'h2a));
    putInstr(32'h10, encR(2, 1, 5, 0, 6'h2b));
    putInstr(32'h14, encI(6'h2b, 0, 3, 8));
    putInstr(32'h18, encI(6'h23, 0, 6, 8));
    putInstr(32'h1C, encI(6'h0d, 0, 0, 32'h55));
    putInstr(32'h20, encI(6'h08, 2, 7, -1));
    putInstr(32'h24, 32'hFC00_0000);
    putInstr(32'h28, encI(6'h05, 1, 1, 5));

    repeat (2) @(negedge CLK);
    checkOutput("por_pc", dut.U_PCU.PCRegDataOut, 32'h0000_0000);
    checkOutput("por_r31", dut.regs_q[31], 32'h0);
    releaseReset();

    applyStimulus(); checkAll(); checkOutput("ori_r1", dut.regs_q[1], 32'h0000_1234);
    applyStimulus(); checkAll(); checkOutput("lui_r2", dut.regs_q[2], 32'h8000_0000);
    applyStimulus(); checkAll(); checkOutput("addu_r3", dut.regs_q[3], 32'h8000_1234);
    applyStimulus(); checkAll(); checkOutput("slt_r4", dut.regs_q[4], 32'h1);
    applyStimulus(); checkAll(); checkOutput("sltu_r5", dut.regs_q[5], 32'h0);
    applyStimulus(); checkAll(); checkOutput("sw_mem2", dut.u_data_memory.dmem[2], 32'h8000_1234);
    applyStimulus(); checkAll(); checkOutput("lw_r6", dut.regs_q[6], 32'h8000_1234);
    applyStimulus(); checkAll(); checkOutput("r0_zero", dut.regs_q[0], 32'h0);
    applyStimulus(); checkAll(); checkOutput("addi_ovf_r7", dut.regs_q[7], 32'h7FFF_FFFF);
    applyStimulus(); checkAll(); checkOutput("undef_pc", dut.U_PCU.PCRegDataOut, 32'h28);
    applyStimulus(); checkAll(); checkOutput("bne_nt_pc", dut.U_PCU.PCRegDataOut, 32'h2C);
    repeat (2) begin applyStimulus(); checkAll(); end

    // Mid-run reset, then Program B: beq that branches to itself.
    assertReset();
    clearProgram();
    putInstr(32'h00, encI(6'h0d, 0, 1, 1));
    putInstr(32'h10, encI(6'h04, 1, 1, -1));
    releaseReset();
    repeat (4) begin applyStimulus(); checkAll(); end
    checkOutput("pre_beq_pc", dut.U_PCU.PCRegDataOut, 32'h10);
    applyStimulus(); checkAll(); checkOutput("beq_self_pc", dut.U_PCU.PCRegDataOut, 32'h10);
    applyStimulus(); checkAll(); checkOutput("beq_self_pc2", dut.U_PCU.PCRegDataOut, 32'h10);

    // Program C: j, jal, jr, back-to-back dependency, variable shift.
    assertReset();
    clearProgram();
    putInstr(32'h000, encJ(6'h02, 8));
    putInstr(32'h020, encJ(6'h03, 32'h40));
    putInstr(32'h100, encR(31, 0, 0, 0, 6'h08));
    putInstr(32'h024, encI(6'h09, 31, 8, 4));
    putInstr(32'h028, encI(6'h0d, 0, 9, 3));
    putInstr(32'h02C, encR(9, 8, 10, 0, 6'h04));
    releaseReset();
    applyStimulus(); checkAll(); checkOutput("j_pc", dut.U_PCU.PCRegDataOut, 32'h20);
    applyStimulus(); checkAll(); checkOutput("jal_pc", dut.U_PCU.PCRegDataOut, 32'h100);
    checkOutput("jal_r31", dut.regs_q[31], 32'h24);
    applyStimulus(); checkAll(); checkOutput("jr_pc", dut.U_PCU.PCRegDataOut, 32'h24);
    applyStimulus(); checkAll(); checkOutput("addiu_r8", dut.regs_q[8], 32'h28);
    applyStimulus(); checkAll(); checkOutput("ori_r9", dut.regs_q[9], 32'h3);
    applyStimulus(); checkAll();
`ifdef MIPS_R2000_SHIFTV_EN
    checkOutput("sllv_r10", dut.regs_q[10], 32'h140);
`else
    checkOutput("sllv_nop_r10", dut.regs_q[10], 32'h0);
`endif

    // Random programs checked every cycle against the model; data memory
    // persists across the reset between rounds.
    for (int round = 0; round < 2; round++) begin
      assertReset();
      clearProgram();
      for (int k = 0; k < 8; k++) putInstr(4 * k, encI(6'h2b, 0, 0, 32'h40 + 4 * k));
      for (int k = 8; k < 160; k++) putInstr(4 * k, randInstr());
      releaseReset();
      repeat (150) begin applyStimulus(); checkAll(); end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mips_r2000_core.md
MIPS_R2000_CORE -- requirements
Module: mips_r2000_core

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 1024: data memory depth in 32-bit words.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value on reset.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have no other ports; instruction memory is instance U_InstructionMemory with array IMem[IMEM_WORDS], hex-loadable from the bench by hierarchical path.
REQ-007 SHALL expose the PC as U_PCU.PCRegDataOut (32 bits) and the fetched word as top-level wire instr (32 bits), for hierarchical monitoring.

Function
REQ-008 SHALL be single-cycle: every instruction fetches, executes and commits PC, register and memory writes on one CLK rising edge.
REQ-009 SHALL fetch instr = IMem[PC[11:2]], combinationally; PC bits [1:0] ignored; index wraps modulo IMEM_WORDS.
REQ-010 SHALL hold 32 x 32-bit registers; $0 reads 0 always; writes to $0 discarded; two combinational read ports, one write port.
REQ-011 SHALL implement R-type add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra (shamt), jr.
REQ-012 SHALL implement I-type addi, addiu, slti, sltiu (sign-extended imm), andi, ori, xori (zero-extended imm), lui (imm<<16), lw, sw, beq, bne.
REQ-013 SHALL implement J-type j and jal; jal writes PC+4 to $31.
REQ-014 SHALL compute next PC: default PC+4; taken branch PC+4+(sext(imm)<<2); j/jal {PC+4[31:28], target, 2'b00}; jr rs value.
REQ-015 SHALL have no branch delay slot.
REQ-016 SHALL perform all arithmetic modulo 2^32; add/addi/sub overflow SHALL NOT trap (identical to unsigned forms).
REQ-017 SHALL compute slt/slti signed and sltu/sltiu unsigned; result is 0 or 1.
REQ-018 SHALL word-address data memory: lw/sw use DMem[(rs+sext(imm))[11:2]], wrapping modulo DMEM_WORDS; low two address bits ignored.
REQ-019 SHALL read data memory combinationally and write it synchronously on the CLK rising edge.
REQ-020 SHALL treat any unsupported opcode/funct as NOP: PC+4, no register or memory write.
REQ-021 SHALL, when an instruction reads a register written by the immediately preceding instruction, see the committed new value (single-cycle, no hazard).

Reset
REQ-022 SHALL, while RST=0, asynchronously force PC=RESET_PC and all 32 registers to 0.
REQ-023 SHALL NOT clear IMem or DMem on reset; DMem powers up at 0 in simulation.
REQ-024 SHALL resume fetch at RESET_PC on the first rising CLK edge after RST returns to 1; reset mid-program aborts the current instruction with no commit.

Configuration
REQ-025 SHALL, when macro MIPS_R2000_SHIFTV_EN is defined, additionally implement sllv, srlv, srav, with shift amount rs[4:0].
REQ-026 SHALL, when MIPS_R2000_SHIFTV_EN is undefined, treat sllv/srlv/srav as NOP per REQ-020.

Verification
REQ-027 SHALL cover reset: assert RST=0 mid-run -> PC=0x00000000 immediately; all registers read 0.
REQ-028 SHALL cover ALU: ori $1,$0,0x1234; lui $2,0x8000; addu $3,$1,$2 -> $3=0x80001234; slt $4,$2,$1 -> 1; sltu $5,$2,$1 -> 0.
REQ-029 SHALL cover memory: sw $3,8($0); lw $6,8($0) -> $6=0x80001234; $0 write attempt -> $0 stays 0.
REQ-030 SHALL cover branches: beq $1,$1,-1 at PC 0x10 -> next PC 0x10; bne $1,$1,x -> PC+4.
REQ-031 SHALL cover jumps: jal 0x40 at PC 0x20 -> PC=0x100, $31=0x24; jr $31 -> PC=0x24.
REQ-032 SHALL cover overflow: addi $7,$2,-1 with $2=0x80000000 -> $7=0x7FFFFFFF, no trap; undefined opcode -> PC+4 only.
